// File: rtl/servant_uart_fifo.sv
// Synchronous show-ahead FIFO for received UART bytes.
// The head entry is always visible on o_data. Pointers carry one extra MSB
// so that full and empty can be told apart when the index bits are equal.
module servant_uart_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow_sticky
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             r_overflow;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A pop on an empty FIFO is ignored; a push into a full FIFO only
    // succeeds if a pop frees the head slot in the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    assign o_data            = r_mem[r_rd_ptr[AW-1:0]];
    assign o_level           = r_wr_ptr - r_rd_ptr;
    assign o_overflow_sticky = r_overflow;

    // Storage, pointer and sticky-overflow update.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_data;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !w_do_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/servant_uart_rx.sv
// 8N1 UART receiver for the servant console line with a small receive FIFO.
//
//   state | meaning
//   IDLE  | line idle; waiting for a falling edge after the line was seen high
//   START | timing to the middle of the start bit to reject glitches
//   DATA  | sampling 8 data bits mid-bit, LSB first
//   STOP  | sampling the stop bit; good stop pushes, low stop flags frame error
module servant_uart_rx #(
    parameter int CLKS_PER_BIT = 280,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_W        = 9
) (
    input  logic                          wb_clk,
    input  logic                          wb_rst,
    input  logic                          i_rx,
    output logic [7:0]                    o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic                          o_frame_err,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } rx_state_t;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic             r_rx_s1;
    logic             r_rx_s2;
    logic             r_rx_prev;
    logic             r_armed;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             r_frame_err;
    logic             w_push;
    logic             w_ferr;
    logic             w_fall;
    logic             w_empty;

    assign w_fall = r_rx_prev && !r_rx_s2;

    // Two-flop synchroniser plus a history flop for falling-edge detection.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= i_rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    // Arm start detection only once the line has been high in IDLE, so a
    // held-low break produces a single frame error instead of a stream.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_armed <= 1'b0;
        end else if (r_state != S_IDLE) begin
            r_armed <= 1'b0;
        end else if (r_rx_s2) begin
            r_armed <= 1'b1;
        end
    end

    // Next-state, bit timing and sampling decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (r_armed && w_fall) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_cnt == HALF_M1) begin
                    w_cnt_nxt = '0;
                    if (!r_rx_s2) begin
                        w_state_nxt = S_DATA;
                        w_idx_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (r_cnt == BIT_M1) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_rx_s2, r_shift[7:1]};
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == BIT_M1) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    if (r_rx_s2) begin
                        w_push = 1'b1;
                    end else begin
                        w_ferr = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // FSM state, counter, bit index, shift register and frame-error pulse.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= 3'd0;
            r_shift     <= 8'h00;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_frame_err <= w_ferr;
        end
    end

    assign o_frame_err = r_frame_err;
    assign o_valid     = !w_empty;

    servant_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk             (wb_clk),
        .i_rst             (wb_rst),
        .i_push            (w_push),
        .i_data            (r_shift),
        .i_pop             (o_valid && i_ready),
        .o_data            (o_data),
        .o_full            (),
        .o_empty           (w_empty),
        .o_level           (o_level),
        .o_overflow_sticky (o_overflow)
    );

endmodule

// File: tb/tb_servant_uart_rx.sv
// Self-checking bench for servant_uart_rx with a byte scoreboard.
module tb_servant_uart_rx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       wb_clk = 1'b0;
    logic       wb_rst;
    logic       i_rx;
    logic       i_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overflow;
    logic [2:0] o_level;

    int         n_chk = 0;
    int         n_err = 0;
    int         pop_cnt = 0;
    int         ferr_cnt = 0;
    int         vrise_cnt = 0;
    bit         prev_valid = 1'b0;
    bit         exp_ovf = 1'b0;
    logic [7:0] exp_q [$];

    always #5 wb_clk = ~wb_clk;

    servant_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .CNT_W        (5)
    ) dut (
        .wb_clk      (wb_clk),
        .wb_rst      (wb_rst),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_err (o_frame_err),
        .o_overflow  (o_overflow),
        .o_level     (o_level)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one cycle; any pop about to happen is scored against the queue.
    task automatic tick();
        logic [7:0] exp;
        if (o_valid === 1'b1 && i_ready === 1'b1) begin
            n_chk++;
            pop_cnt++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pop_unexpected: got %h, required no data", o_data);
            end else begin
                exp = exp_q.pop_front();
                if (o_data !== exp) begin
                    n_err++;
                    $display("FAIL pop_data: got %h, required %h", o_data, exp);
                end
            end
        end
        if (o_frame_err === 1'b1) ferr_cnt++;
        if (o_valid === 1'b1 && !prev_valid) vrise_cnt++;
        prev_valid = (o_valid === 1'b1);
        @(posedge wb_clk);
        @(negedge wb_clk);
    endtask

    task automatic do_reset();
        i_ready = 1'b0;
        wb_rst  = 1'b1;
        repeat (3) tick();
        wb_rst = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        tick();
    endtask

    // Send one 8N1 frame; stop sample (push cycle) is stop-bit tick 10.
    task automatic send_byte(input logic [7:0] b, input bit stop_low,
                             input bit chk_lat, input bit ready_at_push);
        i_rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            repeat (CPB) tick();
        end
        i_rx = stop_low ? 1'b0 : 1'b1;
        for (int k = 0; k < CPB; k++) begin
            if (k == 10) begin
                if (ready_at_push) i_ready = 1'b1;
                if (chk_lat) begin
                    n_chk++;
                    if (o_valid !== 1'b0) begin
                        n_err++;
                        $display("FAIL latency_early: o_valid=%b, required 0", o_valid);
                    end
                end
            end
            tick();
            if (k == 10) begin
                if (ready_at_push) i_ready = 1'b0;
                if (!stop_low) begin
                    if (exp_q.size() < DEPTH) exp_q.push_back(b);
                    else exp_ovf = 1'b1;
                end
                if (chk_lat) begin
                    n_chk++;
                    if (o_valid !== 1'b1) begin
                        n_err++;
                        $display("FAIL latency_rise: o_valid=%b, required 1", o_valid);
                    end
                end
            end
        end
        i_rx = 1'b1;
        repeat (4) tick();
    endtask

    task automatic drain();
        i_ready = 1'b1;
        for (int c = 0; c < 64 && exp_q.size() > 0; c++) tick();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d bytes left, required 0", exp_q.size());
        end
        n_chk++;
        if (o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drain_valid: o_valid=%b, required 0", o_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b, required 0", o_valid); end
        n_chk++;
        if (o_frame_err !== 1'b0) begin n_err++; $display("FAIL rst_ferr: got %b, required 0", o_frame_err); end
        n_chk++;
        if (o_overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b, required 0", o_overflow); end
        n_chk++;
        if (o_level !== 3'd0) begin n_err++; $display("FAIL rst_level: got %0d, required 0", o_level); end
        n_chk++;
        if (o_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h, required 00", o_data); end
    endtask

    task automatic test_basic();
        int p0, v0, f0;
        do_reset();
        i_ready = 1'b1;
        p0 = pop_cnt; v0 = vrise_cnt; f0 = ferr_cnt;
        send_byte(8'h55, 1'b0, 1'b1, 1'b0);
        send_byte(8'h0A, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        n_chk++;
        if (pop_cnt - p0 != 2) begin n_err++; $display("FAIL basic_pops: got %0d, required 2", pop_cnt - p0); end
        n_chk++;
        if (vrise_cnt - v0 != 2) begin n_err++; $display("FAIL basic_valid_pulses: got %0d, required 2", vrise_cnt - v0); end
        n_chk++;
        if (ferr_cnt != f0) begin n_err++; $display("FAIL basic_ferr: got %0d, required 0", ferr_cnt - f0); end
    endtask

    task automatic test_false_start();
        int f0;
        f0 = ferr_cnt;
        i_rx = 1'b0;
        repeat (5) tick();
        i_rx = 1'b1;
        repeat (3 * CPB) tick();
        n_chk++;
        if (o_level !== 3'd0) begin n_err++; $display("FAIL false_start_level: got %0d, required 0", o_level); end
        n_chk++;
        if (o_valid !== 1'b0) begin n_err++; $display("FAIL false_start_valid: got %b, required 0", o_valid); end
        n_chk++;
        if (ferr_cnt != f0) begin n_err++; $display("FAIL false_start_ferr: got %0d, required 0", ferr_cnt - f0); end
    endtask

    task automatic test_frame_err();
        int f0, p0;
        f0 = ferr_cnt; p0 = pop_cnt;
        i_ready = 1'b1;
        send_byte(8'hA5, 1'b1, 1'b0, 1'b0);
        n_chk++;
        if (ferr_cnt - f0 != 1) begin n_err++; $display("FAIL ferr_pulse: got %0d, required 1", ferr_cnt - f0); end
        n_chk++;
        if (pop_cnt != p0 || o_level !== 3'd0) begin
            n_err++;
            $display("FAIL ferr_nopush: pops=%0d level=%0d, required 0 and 0", pop_cnt - p0, o_level);
        end
        send_byte(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        n_chk++;
        if (pop_cnt - p0 != 1) begin n_err++; $display("FAIL ferr_recover: got %0d pops, required 1", pop_cnt - p0); end
        n_chk++;
        if (ferr_cnt - f0 != 1) begin n_err++; $display("FAIL ferr_single: got %0d, required 1", ferr_cnt - f0); end
    endtask

    task automatic test_overflow();
        int p0;
        do_reset();
        i_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0, (i == 1), 1'b0);
        n_chk++;
        if (o_level !== 3'(exp_q.size())) begin n_err++; $display("FAIL ovf_level: got %0d, required %0d", o_level, exp_q.size()); end
        n_chk++;
        if (o_overflow !== exp_ovf) begin n_err++; $display("FAIL ovf_flag: got %b, required %b", o_overflow, exp_ovf); end
        n_chk++;
        if (o_data !== exp_q[0]) begin n_err++; $display("FAIL ovf_head: got %h, required %h", o_data, exp_q[0]); end
        p0 = pop_cnt;
        drain();
        n_chk++;
        if (pop_cnt - p0 != 4) begin n_err++; $display("FAIL ovf_pops: got %0d, required 4", pop_cnt - p0); end
        n_chk++;
        if (o_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b, required 1", o_overflow); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        i_ready = 1'b0;
        send_byte(8'h11, 1'b0, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0, 1'b0);
        send_byte(8'h44, 1'b0, 1'b0, 1'b0);
        send_byte(8'h55, 1'b0, 1'b0, 1'b1);
        n_chk++;
        if (o_level !== 3'(exp_q.size())) begin n_err++; $display("FAIL fullpp_level: got %0d, required %0d", o_level, exp_q.size()); end
        n_chk++;
        if (o_overflow !== exp_ovf) begin n_err++; $display("FAIL fullpp_ovf: got %b, required %b", o_overflow, exp_ovf); end
        n_chk++;
        if (o_data !== exp_q[0]) begin n_err++; $display("FAIL fullpp_head: got %h, required %h", o_data, exp_q[0]); end
    endtask

    task automatic test_reset_midframe();
        int p0;
        i_ready = 1'b0;
        i_rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 4; i++) begin
            i_rx = 1'b1;
            repeat (CPB) tick();
        end
        i_rx = 1'b1;
        repeat (CPB / 2) tick();
        wb_rst = 1'b1;
        repeat (2) tick();
        n_chk++;
        if (o_valid !== 1'b0 || o_level !== 3'd0) begin
            n_err++;
            $display("FAIL midrst_fifo: valid=%b level=%0d, required 0 and 0", o_valid, o_level);
        end
        n_chk++;
        if (o_data !== 8'h00 || o_overflow !== 1'b0 || o_frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_outs: data=%h ovf=%b ferr=%b, required 00 0 0", o_data, o_overflow, o_frame_err);
        end
        wb_rst = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        repeat (6 * CPB) tick();
        n_chk++;
        if (o_level !== 3'd0) begin n_err++; $display("FAIL midrst_partial: got level %0d, required 0", o_level); end
        i_ready = 1'b1;
        p0 = pop_cnt;
        send_byte(8'h12, 1'b0, 1'b0, 1'b0);
        drain();
        n_chk++;
        if (pop_cnt - p0 != 1) begin n_err++; $display("FAIL midrst_resume: got %0d pops, required 1", pop_cnt - p0); end
    endtask

    initial begin
        wb_rst  = 1'b1;
        i_rx    = 1'b1;
        i_ready = 1'b0;
        @(negedge wb_clk);
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err();
        test_overflow();
        test_full_push_pop();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
